// File: rtl/io_responder.sv
// Purpose: memory-mapped IO window (STATUS/TXDATA/CYCLES/SCRATCH/DIVISOR) driving a FIFO-fed UART transmitter.
// Latency: load data is registered one cycle after io_read_en; a queued byte leaves IDLE the next cycle.
// Backpressure: none toward the core; TXDATA writes to a full FIFO are dropped and latch the overflow flag.
module io_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_write_en,
    input  logic        io_read_en,
    input  logic [31:0] io_address,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // Register window decode
    logic [31:0] offset;
    logic        sel_status;
    logic        sel_txdata;
    logic        sel_cycles;
    logic        sel_scratch;
    logic        sel_divisor;

    assign offset = io_address - BASE_ADDR;

    // Word-select decode; the low two address bits are deliberately ignored
    always_comb begin
        sel_status  = 1'b0;
        sel_txdata  = 1'b0;
        sel_cycles  = 1'b0;
        sel_scratch = 1'b0;
        sel_divisor = 1'b0;
        case (offset[31:2])
            30'd0:   sel_status  = 1'b1;
            30'd1:   sel_txdata  = 1'b1;
            30'd2:   sel_cycles  = 1'b1;
            30'd3:   sel_scratch = 1'b1;
            30'd4:   sel_divisor = 1'b1;
            default: ;
        endcase
    end

    logic wr_status;
    logic wr_txdata;
    logic wr_scratch;
    logic wr_divisor;

    assign wr_status  = io_write_en && sel_status;
    assign wr_txdata  = io_write_en && sel_txdata;
    assign wr_scratch = io_write_en && sel_scratch;
    assign wr_divisor = io_write_en && sel_divisor;

    // Architectural registers
    logic [31:0] cycles;
    logic [31:0] scratch;
    logic [15:0] divisor;
    logic        overflow;

    // TX state
    tx_state_t   state;
    logic [7:0]  shreg;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;
    logic [15:0] baud_reload;
    logic        tx_busy;

    // A divisor of zero is treated as one cycle per bit
    assign baud_reload = (divisor == 16'd0) ? 16'd0 : (divisor - 16'd1);
    assign tx_busy     = (state != S_IDLE);

    // TX byte FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic          drop;
    logic [7:0]    fifo_head;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign fifo_head  = fifo_mem[rd_ptr];

    // Pop happens exactly when the FSM enters START (from IDLE or from the end of STOP)
    assign pop  = !fifo_empty && ((state == S_IDLE) || ((state == S_STOP) && (baud_cnt == 16'd0)));
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign push = wr_txdata && (!fifo_full || pop);
    assign drop = wr_txdata && fifo_full && !pop;

    // FIFO storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= io_write_data[7:0];
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Overflow is sticky until software writes STATUS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (wr_status) begin
            overflow <= 1'b0;
        end
    end

    // Free-running cycle counter, read-only to software
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= 32'd0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // Software-writable SCRATCH and DIVISOR registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scratch <= 32'd0;
            divisor <= 16'd16;
        end else begin
            if (wr_scratch) begin
                scratch <= io_write_data;
            end
            if (wr_divisor) begin
                divisor <= io_write_data[15:0];
            end
        end
    end

    // Read mux uses current register values, so a same-cycle write returns the old contents
    logic [4:0]  count_ext;
    logic [31:0] status_word;
    logic [31:0] read_mux;

    assign count_ext   = 5'(fifo_count);
    assign status_word = {25'd0, count_ext[3:0], overflow, tx_busy, !fifo_full};

    // Select the load data for the addressed register
    always_comb begin
        read_mux = 32'd0;
        if (sel_status) begin
            read_mux = status_word;
        end else if (sel_cycles) begin
            read_mux = cycles;
        end else if (sel_scratch) begin
            read_mux = scratch;
        end else if (sel_divisor) begin
            read_mux = {16'd0, divisor};
        end
    end

    // Load data register holds between reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_read_data <= 32'd0;
        end else if (io_read_en) begin
            io_read_data <= read_mux;
        end
    end

    // UART transmit FSM; uart_tx is a registered output updated on every bit boundary
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            uart_tx  <= 1'b1;
            shreg    <= 8'd0;
            bit_idx  <= 3'd0;
            baud_cnt <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state    <= S_START;
                        uart_tx  <= 1'b0;
                        shreg    <= fifo_head;
                        baud_cnt <= baud_reload;
                    end
                end
                S_START: begin
                    if (baud_cnt == 16'd0) begin
                        state    <= S_DATA;
                        uart_tx  <= shreg[0];
                        bit_idx  <= 3'd0;
                        baud_cnt <= baud_reload;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_cnt == 16'd0) begin
                        baud_cnt <= baud_reload;
                        if (bit_idx == 3'd7) begin
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (baud_cnt == 16'd0) begin
                        if (!fifo_empty) begin
                            state    <= S_START;
                            uart_tx  <= 1'b0;
                            shreg    <= fifo_head;
                            baud_cnt <= baud_reload;
                        end else begin
                            state   <= S_IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

    // Bits intentionally left unobserved
    logic unused_bits;
    assign unused_bits = &{1'b0, offset[1:0], count_ext[4]};

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

    localparam logic [31:0] BASE     = 32'hFFFF0000;
    localparam logic [31:0] A_STATUS = BASE + 32'h00;
    localparam logic [31:0] A_TX     = BASE + 32'h04;
    localparam logic [31:0] A_CYC    = BASE + 32'h08;
    localparam logic [31:0] A_SCR    = BASE + 32'h0C;
    localparam logic [31:0] A_DIV    = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_write_en = 1'b0;
    logic        io_read_en = 1'b0;
    logic [31:0] io_address = 32'd0;
    logic [31:0] io_write_data = 32'd0;
    logic [31:0] io_read_data;
    logic        uart_tx;

    int n_cmp = 0;
    int n_fail = 0;

    // Expected uart_tx level, one entry per clock cycle
    bit exp_q[$];

    io_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_write_en   (io_write_en),
        .io_read_en    (io_read_en),
        .io_address    (io_address),
        .io_write_data (io_write_data),
        .io_read_data  (io_read_data),
        .uart_tx       (uart_tx)
    );

    always #5 clk = ~clk;

    // Bus helpers: entered and left on a falling edge, each spans one rising edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        io_write_en   = 1'b1;
        io_address    = a;
        io_write_data = d;
        @(negedge clk);
        io_write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        io_read_en = 1'b1;
        io_address = a;
        @(negedge clk);
        io_read_en = 1'b0;
        d = io_read_data;
    endtask

    // Reference frame: start 0, data LSB first, stop 1, each level held max(div,1) cycles
    task automatic model_frame(input logic [7:0] b, input int unsigned div);
        int unsigned eff;
        eff = (div == 0) ? 1 : div;
        repeat (eff) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (eff) exp_q.push_back(b[i]);
        end
        repeat (eff) exp_q.push_back(1'b1);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (io_read_data !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want %h", io_read_data, 32'd0); end
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        reset = 1'b1;
        @(negedge clk);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL reset_status: got %h want %h", d, 32'h1); end
        bus_read(A_DIV, d);
        n_cmp++;
        if (d !== 32'd16) begin n_fail++; $display("FAIL reset_divisor: got %h want %h", d, 32'd16); end
        bus_read(A_SCR, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL reset_scratch: got %h want %h", d, 32'd0); end
        // Counter started at 0 at the first edge after release; this read is the fifth edge
        bus_read(A_CYC, d);
        n_cmp++;
        if (d !== 32'd4) begin n_fail++; $display("FAIL reset_cycles: got %h want %h", d, 32'd4); end
    endtask

    task automatic test_scratch;
        logic [31:0] d;
        logic [31:0] v;
        bus_write(A_SCR, 32'hDEADBEEF);
        bus_read(A_SCR, d);
        n_cmp++;
        if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL scratch_deadbeef: got %h want %h", d, 32'hDEADBEEF); end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (io_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold: got %h want %h", io_read_data, 32'hDEADBEEF); end
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            bus_write(A_SCR, v);
            bus_read(A_SCR, d);
            n_cmp++;
            if (d !== v) begin n_fail++; $display("FAIL scratch_rand: got %h want %h", d, v); end
        end
    endtask

    task automatic test_divisor;
        logic [31:0] d;
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            bus_write(A_DIV, v);
            bus_read(A_DIV, d);
            n_cmp++;
            if (d !== {16'd0, v[15:0]}) begin n_fail++; $display("FAIL divisor_rw: got %h want %h", d, {16'd0, v[15:0]}); end
        end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        bus_write(A_SCR, 32'h12345678);
        bus_write(BASE + 32'h14, 32'hFFFFFFFF);
        bus_write(BASE - 32'h4, 32'hFFFFFFFF);
        bus_read(A_SCR, d);
        n_cmp++;
        if (d !== 32'h12345678) begin n_fail++; $display("FAIL unmapped_write: got %h want %h", d, 32'h12345678); end
        bus_read(A_SCR + 32'h3, d);
        n_cmp++;
        if (d !== 32'h12345678) begin n_fail++; $display("FAIL low_bits_ignored: got %h want %h", d, 32'h12345678); end
        bus_read(A_TX, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL txdata_read: got %h want 0", d); end
        bus_read(BASE + 32'h14, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_above: got %h want 0", d); end
        bus_read(BASE - 32'h4, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_below: got %h want 0", d); end
    endtask

    task automatic test_simultaneous;
        logic [31:0] d;
        bus_write(A_SCR, 32'd1);
        io_read_en    = 1'b1;
        io_write_en   = 1'b1;
        io_address    = A_SCR;
        io_write_data = 32'd2;
        @(negedge clk);
        io_read_en  = 1'b0;
        io_write_en = 1'b0;
        n_cmp++;
        if (io_read_data !== 32'd1) begin n_fail++; $display("FAIL rw_same_cycle: got %h want %h", io_read_data, 32'd1); end
        bus_read(A_SCR, d);
        n_cmp++;
        if (d !== 32'd2) begin n_fail++; $display("FAIL rw_after: got %h want %h", d, 32'd2); end
    endtask

    task automatic test_cycles;
        logic [31:0] d1;
        logic [31:0] d2;
        bus_read(A_CYC, d1);
        repeat (9) @(negedge clk);
        bus_read(A_CYC, d2);
        n_cmp++;
        if ((d2 - d1) !== 32'd10) begin n_fail++; $display("FAIL cycles_delta: got %0d want 10", d2 - d1); end
        bus_write(A_CYC, 32'h0);
        bus_read(A_CYC, d1);
        n_cmp++;
        if (d1 === 32'h0) begin n_fail++; $display("FAIL cycles_write_ignored: got %h want nonzero", d1); end
        force dut.cycles = 32'hFFFFFFFF;
        release dut.cycles;
        io_read_en = 1'b1;
        io_address = A_CYC;
        @(negedge clk);
        n_cmp++;
        if (io_read_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL cycles_max: got %h want %h", io_read_data, 32'hFFFFFFFF); end
        @(negedge clk);
        io_read_en = 1'b0;
        n_cmp++;
        if (io_read_data !== 32'h0) begin n_fail++; $display("FAIL cycles_wrap: got %h want %h", io_read_data, 32'h0); end
    endtask

    task automatic test_tx_a5;
        logic [31:0] d;
        bit e;
        bus_write(A_DIV, 32'd4);
        exp_q = {};
        exp_q.push_back(1'b1);
        model_frame(8'hA5, 4);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        bus_write(A_TX, 32'h000000A5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (uart_tx !== e) begin n_fail++; $display("FAIL tx_a5_bit: got %b want %b at %0t", uart_tx, e, $time); end
            @(negedge clk);
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL tx_a5_status: got %h want %h", d, 32'h1); end
    endtask

    task automatic test_tx_random;
        logic [31:0] d;
        logic [7:0]  bytes [4];
        int unsigned div;
        int unsigned n;
        bit e;
        for (int r = 0; r < 4; r++) begin
            div = $urandom_range(0, 5);
            n   = $urandom_range(1, 4);
            bus_write(A_DIV, div);
            exp_q = {};
            exp_q.push_back(1'b1);
            for (int j = 0; j < 4; j++) begin
                bytes[j] = 8'($urandom);
                if (j < int'(n)) model_frame(bytes[j], div);
            end
            exp_q.push_back(1'b1);
            exp_q.push_back(1'b1);
            for (int c = 0; exp_q.size() > 0; c++) begin
                if (c < int'(n)) begin
                    io_write_en   = 1'b1;
                    io_address    = A_TX;
                    io_write_data = {24'd0, bytes[c]};
                end else begin
                    io_write_en = 1'b0;
                end
                @(negedge clk);
                e = exp_q.pop_front();
                n_cmp++;
                if (uart_tx !== e) begin n_fail++; $display("FAIL tx_rand_bit: got %b want %b div %0d at %0t", uart_tx, e, div, $time); end
            end
            io_write_en = 1'b0;
            bus_read(A_STATUS, d);
            n_cmp++;
            if (d !== 32'h1) begin n_fail++; $display("FAIL tx_rand_status: got %h want %h", d, 32'h1); end
        end
    endtask

    task automatic test_div_change;
        logic [7:0] b;
        bit e;
        b = 8'($urandom);
        bus_write(A_DIV, 32'd3);
        // START was loaded with 3 before the change lands; all later bits use 5
        exp_q = {};
        exp_q.push_back(1'b1);
        repeat (3) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (5) exp_q.push_back(b[i]);
        end
        repeat (5) exp_q.push_back(1'b1);
        exp_q.push_back(1'b1);
        for (int c = 0; exp_q.size() > 0; c++) begin
            io_write_en = (c < 2);
            io_address    = (c == 0) ? A_TX : A_DIV;
            io_write_data = (c == 0) ? {24'd0, b} : 32'd5;
            @(negedge clk);
            e = exp_q.pop_front();
            n_cmp++;
            if (uart_tx !== e) begin n_fail++; $display("FAIL div_change_bit: got %b want %b at %0t", uart_tx, e, $time); end
        end
        io_write_en = 1'b0;
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        bus_write(A_DIV, 32'd100);
        // Ten back-to-back writes: the first byte departs into the shifter one cycle after
        // arriving, eight more fill the FIFO, the tenth is dropped.
        for (int i = 0; i < 10; i++) begin
            bus_write(A_TX, 32'($urandom));
        end
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d[2] !== 1'b1) begin n_fail++; $display("FAIL overflow_bit: got %b want 1", d[2]); end
        n_cmp++;
        if (d !== 32'h46) begin n_fail++; $display("FAIL overflow_status: got %h want %h", d, 32'h46); end
        bus_write(A_STATUS, 32'd0);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h42) begin n_fail++; $display("FAIL overflow_clear: got %h want %h", d, 32'h42); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_write(A_SCR, 32'h5A5A5A5A);
        bus_read(A_SCR, d);
        bus_write(A_DIV, 32'd4);
        bus_write(A_TX, 32'h000000F0);
        // 18 edges later the line is in the middle of data bit 3 (a 0 for 8'hF0)
        repeat (18) @(negedge clk);
        n_cmp++;
        if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL midframe_bit3: got %b want 0", uart_tx); end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL midframe_async_tx: got %b want 1", uart_tx); end
        n_cmp++;
        if (io_read_data !== 32'd0) begin n_fail++; $display("FAIL midframe_async_rdata: got %h want 0", io_read_data); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h1) begin n_fail++; $display("FAIL post_reset_status: got %h want %h", d, 32'h1); end
        bus_read(BASE + 32'h20, d);
        n_cmp++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL post_reset_unmapped: got %h want 0", d); end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle_tx: got %b want 1", uart_tx); end
    endtask

    initial begin
        test_reset;
        test_scratch;
        test_divisor;
        test_decode;
        test_simultaneous;
        test_cycles;
        test_tx_a5;
        test_tx_random;
        test_div_change;
        test_overflow;
        test_reset_midframe;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
